// File: rtl/leb128_encoder.sv
// Streaming LEB128 encoder: one WIDTH-bit value in, a sequence of 7-bit
// groups out (low group first), with a continuation flag in bit 7 of each byte.
// Both ULEB128 and SLEB128 are supported, selected per value.
module leb128_encoder #(
   parameter int WIDTH = 64,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_signed,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [7:0]       out_byte,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic [IDX_W-1:0] out_index,
   output logic             busy
);
   // 7 guard bits above the value hold the sign extension of narrow signed
   // inputs, so the last group always sees the correct sign bits.
   localparam int SH_W = WIDTH + 7;

   typedef enum logic {IDLE, EMIT} state_t;

   state_t          state, state_nxt;
   logic [SH_W-1:0] sh, sh_load, rest;
   logic            sgn;
   logic [IDX_W-1:0] idx;
   logic [6:0]      grp;
   logic            last;
   logic            accept, advance;

   assign sh_load = in_signed ? {{7{in_data[WIDTH-1]}}, in_data} : {7'b0, in_data};
   assign grp     = sh[6:0];
   // Shift is spelled out so arithmetic vs logical never depends on
   // expression signedness rules.
   assign rest    = sgn ? {{7{sh[SH_W-1]}}, sh[SH_W-1:7]} : {7'b0, sh[SH_W-1:7]};
   assign accept  = (state == IDLE) && in_valid;
   assign advance = (state == EMIT) && out_ready && !last;

   // Termination: unsigned stops when nothing is left; signed stops when the
   // remaining bits are pure sign and agree with bit 6 of the current group.
   always_comb begin
      last = 1'b0;
      if (sgn)
         last = ((rest == '0) && !grp[6]) || ((&rest) && grp[6]);
      else
         last = (rest == '0);
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state and handshake outputs; byte fields come from registers only.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_byte  = 8'h00;
      out_last  = 1'b0;
      out_index = '0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = EMIT;
         end
         EMIT: begin
            out_valid = 1'b1;
            out_byte  = {~last, grp};
            out_last  = last;
            out_index = idx;
            if (out_ready && last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = ~in_ready;

   // Datapath: load on accept, shift one group per non-final handshake.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh  <= '0;
         sgn <= 1'b0;
         idx <= '0;
      end else if (accept) begin
         sh  <= sh_load;
         sgn <= in_signed;
         idx <= '0;
      end else if (advance) begin
         sh  <= rest;
         idx <= idx + 1'b1;
      end
   end
endmodule

// File: tb/tb_leb128_encoder.sv
module tb_leb128_encoder;
   logic        clk;
   logic        reset;
   logic [63:0] in_data;
   logic        in_signed;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  out_byte;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic [3:0]  out_index;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   logic [7:0] got_b [16];
   logic [3:0] got_i [16];
   logic       got_l [16];
   int         got_n;
   logic       got_done;

   leb128_encoder #(.WIDTH(64), .IDX_W(4)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_signed(in_signed),
      .in_valid(in_valid), .in_ready(in_ready), .out_byte(out_byte),
      .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .out_index(out_index), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stall monitor: a byte presented while out_ready=0 must still be there,
   // unchanged, one cycle later.
   logic       m_stall = 1'b0;
   logic       m_rst   = 1'b1;
   logic [7:0] m_b;
   logic [3:0] m_i;
   always @(negedge clk) begin
      #1;
      if (!reset && !m_rst && m_stall) begin
         checks++;
         if (out_valid !== 1'b1 || out_byte !== m_b || out_index !== m_i) begin
            failures++;
            $display("FAIL stall_hold got v=%b b=%h i=%0d exp v=1 b=%h i=%0d",
                     out_valid, out_byte, out_index, m_b, m_i);
         end
      end
      m_stall = out_valid && !out_ready;
      m_b     = out_byte;
      m_i     = out_index;
      m_rst   = reset;
   end

   // Stimulus helper: submit one value with out_ready=1 and collect bytes,
   // bounded so a stuck DUT leaves got_done=0.
   task automatic run_encode(input logic [63:0] v, input logic s);
      got_n = 0; got_done = 1'b0;
      @(negedge clk);
      in_data = v; in_signed = s; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < 16 && !got_done; k++) begin
         if (out_valid === 1'b1) begin
            got_b[got_n] = out_byte;
            got_i[got_n] = out_index;
            got_l[got_n] = out_last;
            got_n++;
            if (out_last === 1'b1) got_done = 1'b1;
         end
         if (!got_done) @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; in_valid = 1'b0; in_data = '0; in_signed = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      checks += 6;
      if (in_ready  !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
      if (busy      !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
      if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      if (out_last  !== 1'b0) begin failures++; $display("FAIL rst_out_last got=%b exp=0", out_last); end
      if (out_byte  !== 8'h00) begin failures++; $display("FAIL rst_out_byte got=%h exp=00", out_byte); end
      if (out_index !== 4'd0) begin failures++; $display("FAIL rst_out_index got=%0d exp=0", out_index); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_unsigned;
      logic [7:0] exp [3];
      exp[0] = 8'hE5; exp[1] = 8'h8E; exp[2] = 8'h26;
      run_encode(64'd624485, 1'b0);
      checks++;
      if (!got_done || got_n !== 3) begin failures++; $display("FAIL u624485_len got=%0d exp=3", got_n); end
      for (int i = 0; i < 3; i++) begin
         checks += 3;
         if (got_b[i] !== exp[i]) begin failures++; $display("FAIL u624485_byte%0d got=%h exp=%h", i, got_b[i], exp[i]); end
         if (got_i[i] !== 4'(i)) begin failures++; $display("FAIL u624485_idx%0d got=%0d exp=%0d", i, got_i[i], i); end
         if (got_l[i] !== (i == 2)) begin failures++; $display("FAIL u624485_last%0d got=%b", i, got_l[i]); end
      end
      @(negedge clk);
      checks += 2;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL u624485_ready_after got=%b exp=1", in_ready); end
      if (out_valid !== 1'b0) begin failures++; $display("FAIL u624485_valid_after got=%b exp=0", out_valid); end
   endtask

   task automatic test_signed;
      logic [63:0] v;
      logic [7:0]  exp [3];
      int          n;
      for (int c = 0; c < 6; c++) begin
         v = '0; n = 1; exp[0] = 8'h00; exp[1] = 8'h00; exp[2] = 8'h00;
         case (c)
            0: begin v = -64'sd123456; n = 3; exp[0] = 8'hC0; exp[1] = 8'hBB; exp[2] = 8'h78; end
            1: begin v = 64'd63;       n = 1; exp[0] = 8'h3F; end
            2: begin v = 64'd64;       n = 2; exp[0] = 8'hC0; exp[1] = 8'h00; end
            3: begin v = -64'sd1;      n = 1; exp[0] = 8'h7F; end
            4: begin v = -64'sd64;     n = 1; exp[0] = 8'h40; end
            default: begin v = -64'sd65; n = 2; exp[0] = 8'hBF; exp[1] = 8'h7F; end
         endcase
         run_encode(v, 1'b1);
         checks++;
         if (!got_done || got_n !== n) begin failures++; $display("FAIL s%0d_len got=%0d exp=%0d", c, got_n, n); end
         for (int i = 0; i < n; i++) begin
            checks += 3;
            if (got_b[i] !== exp[i]) begin failures++; $display("FAIL s%0d_byte%0d got=%h exp=%h", c, i, got_b[i], exp[i]); end
            if (got_i[i] !== 4'(i)) begin failures++; $display("FAIL s%0d_idx%0d got=%0d exp=%0d", c, i, got_i[i], i); end
            if (got_l[i] !== (i == n - 1)) begin failures++; $display("FAIL s%0d_last%0d got=%b", c, i, got_l[i]); end
         end
      end
   endtask

   task automatic test_boundaries;
      logic [63:0] v;
      logic        s;
      logic [7:0]  exp [10];
      int          n;
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < 10; i++) exp[i] = 8'h00;
         case (c)
            0: begin v = 64'd0; s = 1'b0; n = 1; end
            1: begin v = '1; s = 1'b0; n = 10;
                  for (int i = 0; i < 9; i++) exp[i] = 8'hFF;
                  exp[9] = 8'h01; end
            2: begin v = 64'h8000_0000_0000_0000; s = 1'b1; n = 10;
                  for (int i = 0; i < 9; i++) exp[i] = 8'h80;
                  exp[9] = 8'h7F; end
            default: begin v = 64'd0; s = 1'b1; n = 1; end
         endcase
         run_encode(v, s);
         checks++;
         if (!got_done || got_n !== n) begin failures++; $display("FAIL b%0d_len got=%0d exp=%0d", c, got_n, n); end
         for (int i = 0; i < n; i++) begin
            checks += 3;
            if (got_b[i] !== exp[i]) begin failures++; $display("FAIL b%0d_byte%0d got=%h exp=%h", c, i, got_b[i], exp[i]); end
            if (got_i[i] !== 4'(i)) begin failures++; $display("FAIL b%0d_idx%0d got=%0d exp=%0d", c, i, got_i[i], i); end
            if (got_l[i] !== (i == n - 1)) begin failures++; $display("FAIL b%0d_last%0d got=%b", c, i, got_l[i]); end
         end
      end
   endtask

   task automatic test_backpressure;
      logic       pat  [5];
      logic [7:0] expb [5];
      logic [3:0] expi [5];
      logic [7:0] dlv  [4];
      int         nd;
      pat[0] = 0; pat[1] = 0; pat[2] = 1; pat[3] = 0; pat[4] = 1;
      expb[0] = 8'hAC; expb[1] = 8'hAC; expb[2] = 8'hAC; expb[3] = 8'h02; expb[4] = 8'h02;
      expi[0] = 0; expi[1] = 0; expi[2] = 0; expi[3] = 1; expi[4] = 1;
      nd = 0;
      @(negedge clk);
      in_data = 64'd300; in_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         out_ready = pat[k];
         checks += 3;
         if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid%0d got=%b exp=1", k, out_valid); end
         if (out_byte !== expb[k]) begin failures++; $display("FAIL bp_byte%0d got=%h exp=%h", k, out_byte, expb[k]); end
         if (out_index !== expi[k]) begin failures++; $display("FAIL bp_idx%0d got=%0d exp=%0d", k, out_index, expi[k]); end
         if (pat[k] && out_valid === 1'b1 && nd < 4) begin dlv[nd] = out_byte; nd++; end
         @(negedge clk);
      end
      out_ready = 1'b1;
      checks += 5;
      if (nd !== 2) begin failures++; $display("FAIL bp_delivered got=%0d exp=2", nd); end
      if (dlv[0] !== 8'hAC) begin failures++; $display("FAIL bp_dlv0 got=%h exp=ac", dlv[0]); end
      if (dlv[1] !== 8'h02) begin failures++; $display("FAIL bp_dlv1 got=%h exp=02", dlv[1]); end
      if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_done_valid got=%b exp=0", out_valid); end
      if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_done_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      in_data = '1; in_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checks += 2;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL rm_pre_valid got=%b exp=1", out_valid); end
      if (out_index !== 4'd3) begin failures++; $display("FAIL rm_pre_idx got=%0d exp=3", out_index); end
      reset = 1'b1;
      #1;
      checks += 4;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL rm_valid got=%b exp=0", out_valid); end
      if (in_ready !== 1'b1) begin failures++; $display("FAIL rm_ready got=%b exp=1", in_ready); end
      if (busy !== 1'b0) begin failures++; $display("FAIL rm_busy got=%b exp=0", busy); end
      if (out_index !== 4'd0) begin failures++; $display("FAIL rm_idx got=%0d exp=0", out_index); end
      @(negedge clk);
      reset = 1'b0;
      run_encode(64'd5, 1'b0);
      checks += 4;
      if (!got_done || got_n !== 1) begin failures++; $display("FAIL rm_len got=%0d exp=1", got_n); end
      if (got_b[0] !== 8'h05) begin failures++; $display("FAIL rm_byte got=%h exp=05", got_b[0]); end
      if (got_i[0] !== 4'd0) begin failures++; $display("FAIL rm_idx0 got=%0d exp=0", got_i[0]); end
      if (got_l[0] !== 1'b1) begin failures++; $display("FAIL rm_last got=%b exp=1", got_l[0]); end
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      in_data = 64'd300; in_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      checks += 2;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bb_ready0 got=%b exp=0", in_ready); end
      if (out_byte !== 8'hAC) begin failures++; $display("FAIL bb_byte0 got=%h exp=ac", out_byte); end
      in_data = 64'd777;
      @(negedge clk);
      checks += 3;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bb_ready1 got=%b exp=0", in_ready); end
      if (out_byte !== 8'h02) begin failures++; $display("FAIL bb_byte1 got=%h exp=02", out_byte); end
      if (out_last !== 1'b1) begin failures++; $display("FAIL bb_last1 got=%b exp=1", out_last); end
      in_data = 64'd12345;
      @(negedge clk);
      checks += 2;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL bb_ready2 got=%b exp=1", in_ready); end
      if (out_valid !== 1'b0) begin failures++; $display("FAIL bb_valid2 got=%b exp=0", out_valid); end
      in_data = 64'd5;
      @(negedge clk);
      checks += 3;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL bb_valid3 got=%b exp=1", out_valid); end
      if (out_byte !== 8'h05) begin failures++; $display("FAIL bb_byte3 got=%h exp=05", out_byte); end
      if (out_last !== 1'b1) begin failures++; $display("FAIL bb_last3 got=%b exp=1", out_last); end
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL bb_valid4 got=%b exp=0", out_valid); end
   endtask

   initial begin
      test_reset;
      test_unsigned;
      test_signed;
      test_boundaries;
      test_backpressure;
      test_reset_mid;
      test_back_to_back;
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/leb128_encoder.md
Name: leb128_encoder

Overview:
- Streaming LEB128 encoder. It converts one 64-bit value per transaction into the byte sequence that the CPU's immediate decoder consumes.
- Supports unsigned (ULEB128) and signed (SLEB128) encoding, selected per value.
- Used by the bytecode loader and debug path to build i32/i64 `const` immediates and indices in ROM images.
- Valid/ready on both sides; emits one byte per accepted output handshake.

Parameters:
- WIDTH, 64, bit width of the input value; must be 1..64.
- IDX_W, 4, width of out_index; must hold ceil(WIDTH/7)-1 (10 bytes max for 64).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_data  input  WIDTH  value to encode
- in_signed  input  1  1 = SLEB128, 0 = ULEB128; sampled with in_data
- in_valid  input  1  producer has a value
- in_ready  output  1  encoder idle, can accept a value
- out_byte  output  8  current encoded byte: {continuation, 7 payload bits}
- out_valid  output  1  out_byte is valid
- out_ready  input  1  consumer accepts out_byte
- out_last  output  1  out_byte is the final byte; continuation bit is 0
- out_index  output  IDX_W  position of out_byte within the sequence, starting at 0
- busy  output  1  encoding in progress; equals ~in_ready

Behaviour:
- Clock and reset: one clock `clk`. `reset` is asynchronous and active-high.
- Reset values:
  - State is IDLE; shift register and index are 0; signed flag is 0.
  - Outputs: in_ready=1, busy=0, out_valid=0, out_last=0, out_byte=0, out_index=0.
- States: IDLE and EMIT.
- IDLE:
  - in_ready=1 and out_valid=0.
  - On in_valid&in_ready: load sh<=in_data, sgn<=in_signed, idx<=0, then go to EMIT.
  - Acceptance-to-first-byte latency is 1 cycle.
- EMIT:
  - in_ready=0 and out_valid=1.
  - out_byte, out_last and out_index are decoded combinationally from registers only; they must not depend on out_ready.
- Per-byte decode:
  - grp=sh[6:0].
  - rest = sh>>7: arithmetic shift if sgn, logical shift otherwise.
  - Unsigned termination: last = (rest==0).
  - Signed termination: last = (rest==0 & grp[6]==0) | (rest==all-ones & grp[6]==1).
  - out_byte = {~last, grp}. out_last = last.
- On out_valid&out_ready:
  - If last: return to IDLE.
  - Otherwise: sh<=rest and idx<=idx+1.
- Back-to-back operation:
  - No new value is accepted in the same cycle as the final byte handshake.
  - The next value can be accepted on the following cycle, since in_ready is 1 once in IDLE.
  - Minimum per-value cost is N+1 cycles for an N-byte encoding.
- Backpressure: while out_ready=0, out_byte, out_last and out_index hold stable and no state changes.
- Byte count bounds:
  - Unsigned: bytes = max(1, ceil(msb_pos+1 / 7)).
  - Signed: minimal length such that the sign bit of the last group equals all remaining bits.
  - Never more than ceil(WIDTH/7) bytes.
- WIDTH<64 signed: the value is sign-extended from bit WIDTH-1; the shift register is WIDTH bits plus 7 guard bits to hold the extension.
- Zero:
  - Unsigned 0 encodes to the single byte 0x00.
  - Signed 0 encodes to 0x00.
  - Signed -1 encodes to 0x7F.
- Reset mid-EMIT: the sequence is abandoned immediately (async). No partial completion; out_valid drops with reset.
- in_valid while busy is ignored; in_data may change freely without effect.

Test Plan:
1. Unsigned in_data=624485, out_ready=1 → bytes E5, 8E, 26; out_index 0, 1, 2; out_last only on 26; in_ready returns to 1 the cycle after 26.
2. Signed -123456 → C0, BB, 78. Signed 63 → 3F (one byte). Signed 64 → C0, 00. Signed -1 → 7F. Signed -64 → 40. Signed -65 → BF, 7F.
3. Unsigned 0 → single 00 with out_last=1. Unsigned 0xFFFFFFFFFFFFFFFF → nine FF then 01, out_index 9 on last. Signed 0x8000000000000000 → nine 80 then 7F.
4. Backpressure: encode unsigned 300 (AC, 02) with out_ready toggling 0,0,1,0,1 → AC held stable for 3 cycles and each byte is delivered exactly once; assertions on a stable out_byte/out_index while out_ready=0.
5. Reset: start unsigned 0xFFFFFFFFFFFFFFFF, assert reset after byte 3 mid-cycle → out_valid=0 and in_ready=1 without waiting for a clock; a following encode of 5 yields the single byte 05, out_index 0.
6. Busy handling: hold in_valid=1 with changing in_data during EMIT → only the first value is encoded. The next value is accepted the cycle after out_last handshakes, giving throughput of N+1 cycles per value.
